// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin share of one 8N1 transmitter among byte streams.
// Packets stay contiguous; a stalled owner is evicted after HOLD_TO cycles.
module uart_tx_arb #(
    parameter int N_REQ   = 4,
    parameter int HOLD_TO = 50_000,
    parameter int BUSY_TO = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_active,
    output logic                     evict
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_TO + 1);
    localparam int BW = $clog2(BUSY_TO + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   ptr;
    logic            last_r;
    logic [HW-1:0]   hold_cnt;
    logic [BW-1:0]   busy_cnt;

    logic            any_valid;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;
    logic            xfer;
    logic            do_evict;
    logic            pkt_end;

    // Round-robin scan from ptr+1; the loop runs downward so the
    // nearest valid index after ptr is the one left in pick.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    // Select the current owner's valid/last/data slice.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
            end
        end
    end

    // State register plus registered outputs, pointer and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= IW'(N_REQ - 1);
            grant_id     <= '0;
            grant_active <= 1'b0;
            tx_en        <= 1'b0;
            tx_data      <= 8'h00;
            last_r       <= 1'b0;
            evict        <= 1'b0;
            hold_cnt     <= '0;
            busy_cnt     <= '0;
        end else begin
            state <= state_n;
            tx_en <= (state_n == START);
            evict <= do_evict;
            if (state == IDLE && any_valid) begin
                grant_id     <= pick;
                grant_active <= 1'b1;
            end
            if (xfer) begin
                tx_data <= own_data;
                last_r  <= own_last;
            end
            if (do_evict || pkt_end) begin
                ptr          <= grant_id;
                grant_active <= 1'b0;
            end
            if (state_n != state || xfer) begin
                hold_cnt <= '0;
            end else if (state == SEND && !own_valid &&
                         hold_cnt != HW'(HOLD_TO)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state_n != state) begin
                busy_cnt <= '0;
            end else if (state == WAIT_BUSY &&
                         busy_cnt != BW'(BUSY_TO)) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
        end
    end

    // Next-state logic and the transfer / evict / packet-end strobes.
    always_comb begin
        state_n  = state;
        xfer     = 1'b0;
        do_evict = 1'b0;
        pkt_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) state_n = SEND;
            end
            SEND: begin
                if (own_valid && !tx_busy) begin
                    xfer    = 1'b1;
                    state_n = START;
                end else if (hold_cnt == HW'(HOLD_TO - 1)) begin
                    do_evict = 1'b1;
                    state_n  = IDLE;
                end
            end
            START: begin
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy || busy_cnt == BW'(BUSY_TO - 1))
                    state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_r) begin
                        pkt_end = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Only the owner sees ready, and never while a frame is shifting.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state == SEND && grant_id == IW'(i))
                req_ready[i] = req_valid[i] & ~tx_busy;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of latency, fairness, packet lock,
// eviction, busy timeout and asynchronous reset for uart_tx_arb.
module tb_uart_tx_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           grant_active;
    logic           evict;

    int checks = 0;
    int errors = 0;

    // transmitter model: busy for 10 cycles starting 1 cycle after tx_en
    int   bcnt = 0;
    logic busy_on = 1'b1;

    // requester sources: per-requester byte lists {last,data}
    logic [8:0] mem [N][16];
    int rd [N];
    int wr [N];

    // capture of tx_en events
    logic [7:0] cap_d [32];
    int cap_g [32];
    int cap_t [32];
    int ncap = 0;
    int ev_n = 0;
    int ev_t = 0;
    int viol = 0;
    int cyc = 0;

    uart_tx_arb #(
        .N_REQ(N),
        .HOLD_TO(16),
        .BUSY_TO(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_en(tx_en),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .grant_active(grant_active),
        .evict(evict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_en && busy_on) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = mem[i][rd[i]][7:0];
                req_last[i]       = mem[i][rd[i]][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] d);
        mem[i][wr[i]] = {last, d};
        wr[i]++;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        drive();
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (tx_en && ncap < 32) begin
            cap_d[ncap] = tx_data;
            cap_g[ncap] = int'(grant_id);
            cap_t[ncap] = cyc;
            ncap++;
        end
        if (evict) begin
            ev_n++;
            ev_t = cyc;
        end
        if (tx_busy && req_ready != '0) viol++;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (hs[i]) rd[i]++;
        drive();
    endtask

    task automatic run_until(input int want, input int bound);
        int n;
        n = 0;
        while (ncap < want && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        ncap = 0;
        ev_n = 0;
        ev_t = 0;
        viol = 0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        clear_src();
        #1;
        rst = 1'b1;
        #2;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_grant_active", grant_active, 0);
        chk("rst_evict", evict, 0);
        chk("rst_req_ready", req_ready, 0);

        // single byte from requester 2
        do_reset();
        push(2, 1'b1, 8'h55);
        drive();
        #1;
        chk("sb_c0_ready", req_ready, 0);
        step();
        #1;
        chk("sb_c1_ready", req_ready, 4'b0100);
        chk("sb_c1_gid", grant_id, 2);
        chk("sb_c1_gact", grant_active, 1);
        chk("sb_c1_txen", tx_en, 0);
        step();
        chk("sb_c2_txen", tx_en, 1);
        chk("sb_c2_data", tx_data, 8'h55);
        while (grant_active && cyc < 100) step();
        chk("sb_release_cycle", cyc, 14);
        chk("sb_release_gid", grant_id, 2);
        chk("sb_no_ready_busy", viol, 0);

        // fairness: all four keep single-byte packets pending
        do_reset();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < N; i++)
                push(i, 1'b1, 8'((i + 1) * 16 + n));
        drive();
        run_until(6, 400);
        chk("rr_count", ncap, 6);
        chk("rr_g0", cap_g[0], 0);
        chk("rr_g1", cap_g[1], 1);
        chk("rr_g2", cap_g[2], 2);
        chk("rr_g3", cap_g[3], 3);
        chk("rr_g4", cap_g[4], 0);
        chk("rr_g5", cap_g[5], 1);
        chk("rr_d0", cap_d[0], 8'h10);
        chk("rr_d4", cap_d[4], 8'h11);
        chk("rr_d5", cap_d[5], 8'h21);
        chk("rr_first_t", cap_t[0], 2);
        chk("rr_gap", cap_t[1] - cap_t[0], 14);
        chk("rr_no_ready_busy", viol, 0);

        // packet lock: requester 1 three bytes, requester 0 waiting
        do_reset();
        push(1, 1'b0, 8'hA1);
        push(1, 1'b0, 8'hA2);
        push(1, 1'b1, 8'hA3);
        drive();
        step();
        push(0, 1'b1, 8'h0F);
        drive();
        run_until(4, 400);
        chk("lk_count", ncap, 4);
        chk("lk_d0", cap_d[0], 8'hA1);
        chk("lk_d1", cap_d[1], 8'hA2);
        chk("lk_d2", cap_d[2], 8'hA3);
        chk("lk_d3", cap_d[3], 8'h0F);
        chk("lk_g3", cap_g[3], 0);
        chk("lk_gap", cap_t[1] - cap_t[0], 13);
        chk("lk_no_ready_busy", viol, 0);

        // eviction: requester 3 stalls mid-packet, requester 1 waits
        do_reset();
        push(3, 1'b0, 8'h33);
        drive();
        step();
        push(1, 1'b1, 8'h5A);
        drive();
        run_until(2, 400);
        chk("ev_count", ncap, 2);
        chk("ev_g0", cap_g[0], 3);
        chk("ev_g1", cap_g[1], 1);
        chk("ev_d1", cap_d[1], 8'h5A);
        chk("ev_pulses", ev_n, 1);
        chk("ev_time", ev_t - cap_t[0], 28);
        chk("ev_next_t", cap_t[1] - cap_t[0], 30);

        // busy timeout: transmitter never reports busy
        busy_on = 1'b0;
        do_reset();
        push(0, 1'b1, 8'h77);
        push(2, 1'b1, 8'h99);
        drive();
        run_until(2, 400);
        chk("bt_count", ncap, 2);
        chk("bt_t0", cap_t[0], 2);
        chk("bt_t1", cap_t[1], 14);
        chk("bt_g1", cap_g[1], 2);
        chk("bt_d1", cap_d[1], 8'h99);
        busy_on = 1'b1;

        // asynchronous reset while waiting for the frame to finish
        do_reset();
        push(2, 1'b0, 8'hC2);
        push(2, 1'b1, 8'hC3);
        drive();
        repeat (6) step();
        chk("mr_pre_gact", grant_active, 1);
        chk("mr_pre_data", tx_data, 8'hC2);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_tx_en", tx_en, 0);
        chk("mr_tx_data", tx_data, 0);
        chk("mr_gid", grant_id, 0);
        chk("mr_gact", grant_active, 0);
        chk("mr_evict", evict, 0);
        chk("mr_ready", req_ready, 0);
        clear_src();
        push(0, 1'b1, 8'hE0);
        push(2, 1'b1, 8'hE2);
        drive();
        ncap = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        run_until(1, 400);
        chk("mr_count", ncap, 1);
        chk("mr_first_g", cap_g[0], 0);
        chk("mr_first_d", cap_d[0], 8'hE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmitter (8N1, `send_en`/`send_data`/`busy` style) among `N_REQ` byte-stream requesters. It sits between the requesters (loopback echo path, status reporter, debug printer) and the single `uart_tx` instance. Each requester streams bytes with a valid/ready handshake. Multi-byte packets are kept contiguous via a `last` flag. A stalled packet owner is evicted after a timeout so the line cannot hang.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `HOLD_TO`, 50_000: cycles a locked requester may hold `req_valid` low mid-packet before eviction.
- `BUSY_TO`, 8: cycles to wait for `tx_busy` to rise after `tx_en` before proceeding anyway.

Ports:
- `clk`, in, 1: single clock, all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `N_REQ`: requester i has a byte on its `req_data` slice.
- `req_data`, in, `8*N_REQ`: byte of requester i on bits [8i+7:8i].
- `req_last`, in, `N_REQ`: byte of requester i ends its packet.
- `req_ready`, out, `N_REQ`: byte of requester i accepted this cycle. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_en`, out, 1: one-cycle start pulse to the transmitter.
- `tx_data`, out, 8: byte for the transmitter, valid while `tx_en`=1 and held until the next accept.
- `tx_busy`, in, 1: transmitter is shifting a frame.
- `grant_id`, out, `$clog2(N_REQ)`: current or last owner index.
- `grant_active`, out, 1: a packet lock is held.
- `evict`, out, 1: one-cycle pulse when a lock is dropped by `HOLD_TO`.

## Operation
FSM with five states:
- **IDLE**
  - If any `req_valid` is set, pick the first set index scanning from `(ptr+1) mod N_REQ` upward with wrap-around.
  - Latch it into `grant_id`, set `grant_active`=1, go to SEND.
  - If none is set, stay.
- **SEND**
  - `req_ready[grant_id]` = `req_valid[grant_id] & ~tx_busy`. This is combinational; all other `req_ready` bits are 0.
  - On transfer: register `tx_data` from the owner's slice, register the owner's `req_last` into `last_r`, go to START. The hold counter clears.
  - With `req_valid[grant_id]`=0, the hold counter increments.
  - When the hold counter reaches `HOLD_TO-1`: pulse `evict`, `ptr<=grant_id`, `grant_active<=0`, go to IDLE.
- **START**
  - `tx_en`=1 for exactly this cycle (registered output), then go to WAIT_BUSY.
- **WAIT_BUSY**
  - Wait for `tx_busy`=1, then go to WAIT_DONE.
  - If `BUSY_TO` cycles elapse without `tx_busy`, go to WAIT_DONE anyway.
- **WAIT_DONE**
  - Wait for `tx_busy`=0.
  - If `last_r`=1: `ptr<=grant_id`, `grant_active<=0`, go to IDLE.
  - Else go to SEND, with the lock kept.
- Priority pointer `ptr` changes only on packet end or eviction. A requester therefore never wins twice in a row while another is requesting.
- Non-owner requests during a lock are ignored; they are neither accepted nor dropped.
- Counters saturate and clear on every state entry. The hold counter is sized `$clog2(HOLD_TO+1)` bits, the busy counter `$clog2(BUSY_TO+1)`.

## Timing
- Reset values: state IDLE, `ptr`=`N_REQ-1` (so index 0 wins first), `tx_en`=0, `tx_data`=0, `grant_id`=0, `grant_active`=0, `evict`=0, `req_ready`=0.
- Latency when `tx_busy`=0: `req_valid` seen in IDLE at cycle 0, then SEND/transfer at cycle 1, then `tx_en` at cycle 2.
- Back-to-back bytes of one packet: the next `req_ready` is possible in the first cycle after `tx_busy` falls plus one (WAIT_DONE→SEND).
- `req_ready` is never asserted while `tx_busy`=1.
- Simultaneous requests at the same scan position resolve by lowest index at or after `ptr+1`.
- A requester dropping `req_valid` at the same edge it would be accepted gets no transfer; the hold counter starts.
- `req_last` is sampled only on a transfer.
- Reset mid-packet: returns immediately to reset values. A frame already in the transmitter is not recalled. Requesters must restart their packet.

## Test plan
- Single byte: `req_valid[2]`=1, data 0x55, last=1, `tx_busy` model rises 1 cycle after `tx_en` for 10 cycles. Required: `req_ready[2]` at cycle 1, `tx_en` with 0x55 at cycle 2, `grant_active` drops after busy falls, `grant_id`=2.
- Fairness: all four requesters hold single-byte packets continuously. Required: `tx_en` order after reset is 0,1,2,3,0,1.
- Packet lock: requester 1 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3) while requester 0 requests throughout. Required: `tx_data` sequence A1,A2,A3, then requester 0's byte.
- Eviction: `HOLD_TO`=16; requester 3 sends one byte with last=0, then drops valid; requester 1 is waiting. Required: `evict` pulses 16 cycles after SEND re-entry, and requester 1 is granted next.
- Busy timeout: `tx_busy` tied to 0, two single-byte requests. Required: each `tx_en` is followed by `BUSY_TO` cycles of WAIT_BUSY, and the second request is still serviced.
- Reset mid-packet: assert `rst` while in WAIT_DONE. Required: all outputs return to their reset values asynchronously, and the first grant after release is index 0.
